fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: the producer side of the decode interface. Holds the PC,
//  requests 16-bit instructions from instruction memory (variable latency), presents
//  one instruction plus PC+2 to decode with a valid/stall handshake, applies
//  branch/jump redirects from execute, and stops fetching after HALT (opcode 5'b00000).
// PARAMETERS
//  RESET_PC   16'h0000  PC value loaded on reset
// PORTS
//  clk            in   1   system clock; all state updates on rising edge
//  rst            in   1   synchronous reset, active-high
//  imem_req       out  1   instruction memory request
//  imem_addr      out  16  request address (current PC)
//  imem_done      in   1   response valid; may assert in the same cycle as imem_req
//  imem_rdata     in   16  instruction word, valid when imem_done=1
//  stall          in   1   decode cannot accept this cycle
//  redirect       in   1   branch taken / jump: load redirect_pc
//  redirect_pc    in   16  new PC target
//  inst           out  16  instruction to decode
//  pc_plus2       out  16  address of inst + 2 (link / branch base)
//  inst_valid     out  1   inst/pc_plus2 valid; consumed when inst_valid & ~stall
//  halted         out  1   HALT consumed, pipeline slot empty, no further fetch
// BEHAVIOUR
//  Reset: pc=RESET_PC, inst=16'h0800 (NOP), pc_plus2=0, inst_valid=0, halted=0,
//   imem_req=0, drop=0, state=RUN. Memory is reset together with this block.
//  State machine (RUN, WAIT, HALT):
//   RUN : imem_req = ~redirect & (~inst_valid | ~stall); imem_addr=pc.
//         req & done -> capture (see below), stay RUN. req & ~done -> WAIT.
//   WAIT: imem_req held 1, imem_addr held stable until imem_done. On done -> capture
//         (or discard if drop), -> RUN. No new request issued while in WAIT.
//   HALT: imem_req=0 forever; halted=1 once inst_valid=0. Left only by rst.
//  Capture: inst<=imem_rdata, pc_plus2<=pc+16'd2, pc<=pc+16'd2, inst_valid<=1.
//   If imem_rdata[15:11]==5'b00000 -> state HALT (HALT itself still delivered).
//  Output slot: request issued only if slot empty or being consumed this cycle, so
//   the capture never overwrites an unconsumed instruction. Zero-wait memory and
//   no stall -> one instruction per cycle, latency 1 cycle req->inst_valid.
//  stall with inst_valid=1: inst, pc_plus2, inst_valid held unchanged.
//  Consume without new capture: inst_valid<=0.
//  Redirect (highest priority, RUN/WAIT only): pc<=redirect_pc, inst_valid<=0,
//   no request that cycle. If in WAIT, or imem_done in same cycle: drop<=1 in WAIT
//   (outstanding response discarded on its done, drop cleared); same-cycle done
//   discarded directly. Next request to redirect_pc in following RUN cycle.
//   Redirect in HALT ignored. Redirect and stall together: redirect wins.
//  PC arithmetic 16-bit, wraps 16'hFFFE+2 -> 16'h0000 silently.
//  rst mid-WAIT: abandons outstanding request, drop=0, state RUN at RESET_PC.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[15:0] (instructions captured,
//   excluding discarded) and perf_stall_cnt[15:0] (cycles inst_valid&stall), both
//   reset to 0 by rst, saturate at 16'hFFFF. Undefined: ports and counters absent,
//   all other behaviour identical.
// TESTING
//  1 rst, RESET_PC=0, zero-wait mem, no stall -> imem_addr 0,2,4,... one per cycle;
//    inst_valid=1 from cycle 2; pc_plus2 = 2,4,6 matches each inst.
//  2 stall=1 for 3 cycles with inst=16'h4021 valid -> inst/pc_plus2 held, imem_req=0,
//    no address advance; release -> next addr fetched, no instruction lost/duplicated.
//  3 mem latency 3 cycles; redirect to 16'h0100 in 2nd WAIT cycle -> stale word
//    discarded (inst_valid stays 0), next imem_addr=16'h0100.
//  4 redirect and imem_done same cycle -> returned word discarded, next request 16'h0100.
//  5 fetch 16'h0000 at addr 16'h0006 -> delivered once, imem_req=0 after, halted=1 the
//    cycle after consumption; later redirect has no effect; rst restarts at RESET_PC.
//  6 FETCH_PERF_EN: 5 captures, 2 stall cycles -> perf_fetch_cnt=5, perf_stall_cnt=2;
//    rst -> both 0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the PC, issues 16-bit fetches to a variable-latency instruction memory,
// presents inst/pc_plus2 to decode with a valid/stall handshake, applies redirects
// from execute and stops fetching after a HALT (opcode 5'b00000).
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] inst,
    output logic [15:0] pc_plus2,
    output logic        inst_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned OPW  = 5;
    localparam logic [XLEN-1:0] NOP_INST = 16'h0800;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(2);
    localparam logic [OPW-1:0]  HALT_OP  = 5'b00000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [XLEN-1:0]   pc_plus2_q, pc_plus2_d;
    logic              inst_valid_q, inst_valid_d;
    logic              drop_q, drop_d;
    logic              halted_q, halted_d;
    logic              capture_c;
    logic              consume_c;

    // Next-state, memory request and output-slot update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        inst_d       = inst_q;
        pc_plus2_d   = pc_plus2_q;
        inst_valid_d = inst_valid_q;
        drop_d       = drop_q;
        imem_req     = 1'b0;
        imem_addr    = pc_q;
        capture_c    = 1'b0;
        consume_c    = inst_valid_q & ~stall;

        case (state_q)
            ST_RUN: begin
                // Only fetch when the slot is empty or drains this cycle
                imem_req = ~rst & ~redirect & (~inst_valid_q | ~stall);
                if (redirect) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                end else if (imem_req) begin
                    if (imem_done) begin
                        capture_c = 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        req_addr_d = pc_q;
                        if (consume_c) inst_valid_d = 1'b0;
                    end
                end else if (consume_c) begin
                    inst_valid_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // Outstanding request held with a stable address until done
                imem_req  = ~rst;
                imem_addr = req_addr_q;
                if (consume_c) inst_valid_d = 1'b0;
                if (redirect) begin
                    pc_d         = redirect_pc;
                    inst_valid_d = 1'b0;
                    if (imem_done) begin
                        state_d = ST_RUN;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_done) begin
                    state_d = ST_RUN;
                    drop_d  = 1'b0;
                    if (!drop_q) capture_c = 1'b1;
                end
            end
            ST_HALT: begin
                if (consume_c) inst_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (capture_c) begin
            inst_d       = imem_rdata;
            pc_plus2_d   = imem_addr + PC_STEP;
            pc_d         = imem_addr + PC_STEP;
            inst_valid_d = 1'b1;
            if (imem_rdata[15:11] == HALT_OP) state_d = ST_HALT;
        end

        halted_d = (state_d == ST_HALT) & ~inst_valid_d;
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            inst_q       <= NOP_INST;
            pc_plus2_q   <= '0;
            inst_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            inst_q       <= inst_d;
            pc_plus2_q   <= pc_plus2_d;
            inst_valid_q <= inst_valid_d;
            drop_q       <= drop_d;
            halted_q     <= halted_d;
        end
    end

    assign inst       = inst_q;
    assign pc_plus2   = pc_plus2_q;
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] perf_fetch_q;
    logic [XLEN-1:0] perf_stall_q;

    // Saturating counters: delivered fetches and stalled-slot cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (capture_c && (perf_fetch_q != '1)) perf_fetch_q <= perf_fetch_q + XLEN'(1);
            if (inst_valid_q && stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + XLEN'(1);
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
